// File: rtl/disp_sched_pkg.sv
// Shared types and reset constants for the display-enable scheduler.
// Optional feature macro: DISP_SCHED_LOOP_EN (periodic schedule restart).
package disp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } schedState_t;

  localparam schedState_t STATE_RST = IDLE;
  localparam logic        BUSY_RST  = 1'b0;
  localparam logic        DONE_RST  = 1'b0;
  localparam logic        EVENT_RST = 1'b0;

endpackage

// File: rtl/disp_sched_table.sv
// Schedule table: NUM_ENTRIES-deep register file holding (valid, start time,
// display value). One synchronous write port, one combinational read port.
// Only the valid bits are reset; time/value contents are don't-care while
// their entry is invalid.
module disp_sched_table #(
  parameter int NUM_ENTRIES = 16,
  parameter int DISP_WIDTH  = 16,
  parameter int TIME_WIDTH  = 32
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           WrEn,
  input  logic [$clog2(NUM_ENTRIES)-1:0] WrAddr,
  input  logic [TIME_WIDTH-1:0]          WrTime,
  input  logic [DISP_WIDTH-1:0]          WrVal,
  input  logic                           WrValid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] RdAddr,
  output logic                           RdValid,
  output logic [TIME_WIDTH-1:0]          RdTime,
  output logic [DISP_WIDTH-1:0]          RdVal
);

  logic [NUM_ENTRIES-1:0] validMem;
  logic [TIME_WIDTH-1:0]  timeMem [NUM_ENTRIES];
  logic [DISP_WIDTH-1:0]  valMem  [NUM_ENTRIES];

  // Valid bits: cleared asynchronously so a reset table is empty at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      validMem <= '0;
    end else if (WrEn) begin
      validMem[WrAddr] <= WrValid;
    end
  end

  // Entry payload: plain write port, no reset needed.
  always_ff @(posedge Clk) begin
    if (WrEn) begin
      timeMem[WrAddr] <= WrTime;
      valMem[WrAddr]  <= WrVal;
    end
  end

  assign RdValid = validMem[RdAddr];
  assign RdTime  = timeMem[RdAddr];
  assign RdVal   = valMem[RdAddr];

endmodule

// File: rtl/disp_sched_ctrl.sv
// Run-time scheduler for the display-enable vector. Counts cycles from Start
// and loads DispVal from each table entry when its start cycle is reached.
// Optional feature macro: DISP_SCHED_LOOP_EN -- on reaching the end of the
// schedule, restart from entry 0 instead of entering DONE.
module disp_sched_ctrl
  import disp_sched_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int DISP_WIDTH  = 16,
  parameter int TIME_WIDTH  = 32
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           WrEn,
  input  logic [$clog2(NUM_ENTRIES)-1:0] WrAddr,
  input  logic [TIME_WIDTH-1:0]          WrTime,
  input  logic [DISP_WIDTH-1:0]          WrVal,
  input  logic                           WrValid,
  input  logic                           Start,
  input  logic                           Stop,
  output logic [DISP_WIDTH-1:0]          DispVal,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Event,
  output logic [$clog2(NUM_ENTRIES):0]   EntryIdx,
  output logic [TIME_WIDTH-1:0]          CycleCount
);

  localparam int             IDX_W   = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W:0] IDX_END = (IDX_W+1)'(NUM_ENTRIES);

  schedState_t           state, stateNext;
  logic                  rdValid;
  logic [TIME_WIDTH-1:0] rdTime;
  logic [DISP_WIDTH-1:0] rdVal;
  logic                  termHit, fireHit, loopRestart;

  logic [DISP_WIDTH-1:0] dispValNext;
  logic                  eventNext, busyNext, doneNext;
  logic [IDX_W:0]        entryIdxNext;
  logic [TIME_WIDTH-1:0] cycleCountNext;

  function automatic logic [TIME_WIDTH-1:0] satInc(input logic [TIME_WIDTH-1:0] v);
    return (&v) ? v : v + TIME_WIDTH'(1);
  endfunction

  disp_sched_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .DISP_WIDTH  (DISP_WIDTH),
    .TIME_WIDTH  (TIME_WIDTH)
  ) uTable (
    .Clk     (Clk),
    .Reset   (Reset),
    .WrEn    (WrEn),
    .WrAddr  (WrAddr),
    .WrTime  (WrTime),
    .WrVal   (WrVal),
    .WrValid (WrValid),
    .RdAddr  (EntryIdx[IDX_W-1:0]),
    .RdValid (rdValid),
    .RdTime  (rdTime),
    .RdVal   (rdVal)
  );

  // The pending entry is the end of the schedule once the index runs off the
  // table or points at an invalid entry; otherwise it fires once due. The read
  // port shows pre-write contents, so a same-cycle rewrite only counts next cycle.
  assign termHit = (state == RUN) && ((EntryIdx == IDX_END) || !rdValid);
  assign fireHit = (state == RUN) && !termHit && (CycleCount >= rdTime);

`ifdef DISP_SCHED_LOOP_EN
  // Index 0 as terminator means entry 0 is invalid: an empty table must not loop.
  assign loopRestart = termHit && (EntryIdx != '0);
`else
  assign loopRestart = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= STATE_RST;
    else       state <= stateNext;
  end

  // Next-state logic: Stop beats Start, Start restarts from any state.
  always_comb begin
    stateNext = state;
    if (Stop) begin
      stateNext = IDLE;
    end else if (Start) begin
      stateNext = RUN;
    end else if (state == RUN && termHit && !loopRestart) begin
      stateNext = DONE;
    end
  end

  // Output/datapath next values; DispVal is only cleared by Stop or Reset.
  always_comb begin
    dispValNext    = DispVal;
    eventNext      = 1'b0;
    entryIdxNext   = EntryIdx;
    cycleCountNext = CycleCount;
    if (Stop) begin
      dispValNext = '0;
    end else if (Start) begin
      entryIdxNext   = '0;
      cycleCountNext = '0;
    end else if (state == RUN) begin
      if (loopRestart) begin
        entryIdxNext   = '0;
        cycleCountNext = '0;
      end else begin
        if (fireHit) begin
          dispValNext  = rdVal;
          eventNext    = 1'b1;
          entryIdxNext = EntryIdx + (IDX_W+1)'(1);
        end
        cycleCountNext = satInc(CycleCount);
      end
    end
    busyNext = (stateNext == RUN);
    // Done trails entry into DONE by one edge and drops with the leaving command.
    doneNext = (state == DONE) && !Start && !Stop;
  end

  // Output registers: every output comes straight from a flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DispVal    <= '0;
      Event      <= EVENT_RST;
      EntryIdx   <= '0;
      CycleCount <= '0;
      Busy       <= BUSY_RST;
      Done       <= DONE_RST;
    end else begin
      DispVal    <= dispValNext;
      Event      <= eventNext;
      EntryIdx   <= entryIdxNext;
      CycleCount <= cycleCountNext;
      Busy       <= busyNext;
      Done       <= doneNext;
    end
  end

endmodule
